// File: rtl/readout_pkg.sv
// Shared types and constants for the clk125 fill readout sequencer.
package readout_pkg;

  localparam int unsigned HDR_WIDTH       = 152;
  localparam int unsigned ADDR_WIDTH      = 23;
  localparam int unsigned CNT_WIDTH       = 24;
  localparam int unsigned FILLS_WIDTH     = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 1048576;

  // Fill header field positions.
  localparam int unsigned FILL_NUM_LSB = 0;
  localparam int unsigned FILL_NUM_MSB = 23;
  localparam int unsigned ADDR_LSB     = 53;
  localparam int unsigned ADDR_MSB     = 75;
  localparam int unsigned CNT_LSB      = 76;
  localparam int unsigned CNT_MSB      = 99;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_HDR_OUT,
    S_ARM,
    S_WAIT_DONE,
    S_POP,
    S_SETTLE
  } readout_state_t;

  // Counter width able to hold limit-1, never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/readout_watchdog.sv
// Loadable up-counter with clear and enable; terminal_c flags count == LIMIT-1.
module readout_watchdog #(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned W     = readout_pkg::cnt_bits(LIMIT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         terminal_c
);

  logic [W-1:0] count;

  assign terminal_c = (count == W'(LIMIT - 1));

  // Saturates at the terminal value until cleared or reloaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !terminal_c) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fill_readout_ctrl.sv
// Sequences one fill at a time: forward header, program and run the DDR3
// reader under a watchdog, then pop the fill header FIFO.
module fill_readout_ctrl
  import readout_pkg::*;
#(
  parameter int unsigned HDR_W          = HDR_WIDTH,
  parameter int unsigned ADDR_W         = ADDR_WIDTH,
  parameter int unsigned CNT_W          = CNT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk125,
  input  logic              reset_clk125_n,
  input  logic              acq_enabled,
  input  logic              readout_go,
  input  logic              fill_header_fifo_empty,
  input  logic [HDR_W-1:0]  fill_header_fifo_out,
  output logic              fill_header_fifo_rd_en,
  output logic [HDR_W-1:0]  hdr_out_dat,
  output logic              hdr_out_valid,
  input  logic              hdr_out_ready,
  output logic [ADDR_W-1:0] ddr3_rd_start_addr,
  output logic [CNT_W-1:0]  ddr3_rd_burst_cnt,
  output logic              enable_reading,
  input  logic              reading_done,
  input  logic              err_clr,
  output logic              timeout_err,
  output logic              readout_busy,
  output logic [15:0]       fills_read
);

  localparam int unsigned WD_W = cnt_bits(TIMEOUT_CYCLES);

  readout_state_t state;
  logic           wd_clr;
  logic           wd_en;
  logic           wd_done_c;
  logic           timeout_set;

  assign wd_clr      = (state == S_ARM);
  assign wd_en       = (state == S_WAIT_DONE);
  // A done in the terminal cycle takes priority over the timeout.
  assign timeout_set = (state == S_WAIT_DONE) && !reading_done && wd_done_c;

  readout_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (WD_W)
  ) u_watchdog (
    .clk        (clk125),
    .rst_n      (reset_clk125_n),
    .clr        (wd_clr),
    .load       (1'b0),
    .load_val   ('0),
    .en         (wd_en),
    .terminal_c (wd_done_c)
  );

  always_ff @(posedge clk125) begin
    if (!reset_clk125_n) begin
      state                  <= S_IDLE;
      fill_header_fifo_rd_en <= 1'b0;
      hdr_out_dat            <= '0;
      hdr_out_valid          <= 1'b0;
      ddr3_rd_start_addr     <= '0;
      ddr3_rd_burst_cnt      <= '0;
      enable_reading         <= 1'b0;
      timeout_err            <= 1'b0;
      readout_busy           <= 1'b0;
      fills_read             <= '0;
    end else begin
      fill_header_fifo_rd_en <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!fill_header_fifo_empty && !acq_enabled && readout_go) begin
            state        <= S_LATCH;
            readout_busy <= 1'b1;
          end
        end
        S_LATCH: begin
          hdr_out_dat        <= fill_header_fifo_out;
          ddr3_rd_start_addr <= ADDR_W'(fill_header_fifo_out[ADDR_MSB:ADDR_LSB]);
          ddr3_rd_burst_cnt  <= CNT_W'(fill_header_fifo_out[CNT_MSB:CNT_LSB]);
          hdr_out_valid      <= 1'b1;
          state              <= S_HDR_OUT;
        end
        S_HDR_OUT: begin
          if (hdr_out_ready) begin
            hdr_out_valid <= 1'b0;
            if (ddr3_rd_burst_cnt != '0) begin
              state <= S_ARM;
            end else begin
              // Zero-burst fill: forward only, skip the reader.
              state                  <= S_POP;
              fill_header_fifo_rd_en <= 1'b1;
            end
          end
        end
        S_ARM: begin
          enable_reading <= 1'b1;
          state          <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (reading_done || wd_done_c) begin
            enable_reading         <= 1'b0;
            fill_header_fifo_rd_en <= 1'b1;
            state                  <= S_POP;
          end
        end
        S_POP: begin
          fills_read <= fills_read + 16'd1;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          readout_busy <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          readout_busy <= 1'b0;
          state        <= S_IDLE;
        end
      endcase

      if (timeout_set) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  rd_en_never_empty: assert property (@(posedge clk125) disable iff (!reset_clk125_n)
    fill_header_fifo_rd_en |-> !fill_header_fifo_empty);

endmodule

// File: doc/fill_readout_ctrl.md
Name: fill_readout_ctrl

Overview:
- Readout sequencer directly downstream of the ADC-to-DDR3 acquisition block, in the clk125 readout domain.
- When acquisition is disabled, it takes each fill header from the fill header FIFO (FWFT, 152 bits) and forwards the header record downstream with a valid/ready handshake.
- It then programs the DDR3 reader with the start address and burst count, holds enable_reading until reading_done, and pops the FIFO.
- It replaces the manual address/count/enable/pop sequencing done by hand today.

Parameters:
- HDR_W, 152, fill header width.
- ADDR_W, 23, DDR3 128-bit burst address width.
- CNT_W, 24, burst count width.
- TIMEOUT_CYCLES, 1048576, maximum clk125 cycles to wait for reading_done.

Ports:
- clk125  in  1  readout clock.
- reset_clk125_n  in  1  synchronous, active-low reset.
- acq_enabled  in  1  1 = acquisition mode; no new fill is started while high.
- readout_go  in  1  level; software permits automatic readout.
- fill_header_fifo_empty  in  1  FWFT FIFO empty flag.
- fill_header_fifo_out  in  HDR_W  header at FIFO head. [23:0] fill number, [75:53] start address, [99:76] burst count.
- fill_header_fifo_rd_en  out  1  one-cycle pop strobe.
- hdr_out_dat  out  HDR_W  registered copy of the current header.
- hdr_out_valid  out  1  header record available downstream.
- hdr_out_ready  in  1  downstream accepts the header.
- ddr3_rd_start_addr  out  ADDR_W  to the DDR3 reader.
- ddr3_rd_burst_cnt  out  CNT_W  to the DDR3 reader.
- enable_reading  out  1  level; high while the reader runs.
- reading_done  in  1  reader complete (pulse or level).
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky watchdog error.
- readout_busy  out  1  high in any state except IDLE.
- fills_read  out  16  count of fills completed (popped); wraps.

Behaviour:
- Reset: all outputs are 0 and the FSM enters IDLE. This applies mid-operation too: enable_reading drops on the first clk125 edge with reset low.
- IDLE -> LATCH when !fill_header_fifo_empty && !acq_enabled && readout_go.
- LATCH (1 cycle):
  - Register the header into hdr_out_dat.
  - Drive ddr3_rd_start_addr = hdr[75:53] and ddr3_rd_burst_cnt = hdr[99:76].
  - Go to HDR_OUT.
- HDR_OUT:
  - hdr_out_valid = 1; hdr_out_dat is held stable until the handshake.
  - On hdr_out_valid && hdr_out_ready: drop valid next cycle.
  - Then go to ARM if burst count != 0, else to POP. A zero-burst fill is forwarded and popped without reading.
- ARM (1 cycle): set enable_reading = 1, clear the watchdog, go to WAIT_DONE.
  - Address and count stay stable from LATCH until enable_reading falls.
- WAIT_DONE:
  - The watchdog increments each cycle.
  - reading_done = 1: enable_reading goes to 0 next cycle, then POP.
  - Watchdog reaches TIMEOUT_CYCLES-1 without done: enable_reading goes to 0, timeout_err is set, then POP (the fill is discarded and sequencing continues).
  - If done and timeout occur in the same cycle, done wins and no error is raised.
- POP: fill_header_fifo_rd_en = 1 for exactly one cycle, fills_read +1 (wraps 0xFFFF -> 0), then SETTLE.
- SETTLE (1 cycle): lets the FWFT empty/data update, then IDLE. Back-to-back fills therefore take at least 6 cycles of overhead.
- acq_enabled or readout_go falling mid-fill: the current fill completes; gating applies only to the IDLE -> LATCH transition.
- timeout_err: cleared by err_clr. If err_clr and a new timeout occur in the same cycle, the set wins.
- fill_header_fifo_rd_en is never asserted when fill_header_fifo_empty = 1; an assertion check covers this.
- readout_busy = (state != IDLE).

Decomposition:
- Shared package `readout_pkg` holds:
  - the FSM state enum (IDLE, LATCH, HDR_OUT, ARM, WAIT_DONE, POP, SETTLE);
  - header field constants (FILL_NUM_LSB/MSB 0/23, ADDR_LSB/MSB 53/75, CNT_LSB/MSB 76/99);
  - the widths.
- One natural sub-module, `readout_watchdog`: a loadable counter with clear, enable and a terminal flag, reusable elsewhere.

Test Plan:
- Reset, then one header (addr 0x000100, cnt 10, fill 0x55), acq_enabled = 0, readout_go = 1 -> hdr_out_valid within 2 cycles; after ready, enable_reading = 1 with addr 0x000100 and cnt 10; reading_done 50 cycles later -> single rd_en pulse, fills_read = 1.
- Three queued headers with hdr_out_ready held low for 20 cycles -> hdr_out_dat stable and no enable_reading until ready; all three read in FIFO order; fills_read = 3.
- Header with cnt 0 -> header forwarded, enable_reading never asserted, popped, fills_read = 1.
- TIMEOUT_CYCLES = 64, reading_done never asserted -> enable_reading drops after 64 cycles, timeout_err = 1, FIFO popped; err_clr pulse -> timeout_err = 0.
- acq_enabled = 1 with a non-empty FIFO -> stays IDLE; raise acq_enabled during WAIT_DONE -> current fill finishes and the next is not started.
- reset_clk125_n low during WAIT_DONE -> all outputs 0 next edge, no rd_en pulse, FIFO contents untouched.
